// File: rtl/reg_rename_file_pkg.sv
// Shared widths, types and constants for the rename register file.
// ROB_IDX_LN sets the ROB index width. NO_ROB_TAG (0) is the reserved "not renamed" tag.
// Word and register-index types are shared by the top and its read ports.
package reg_rename_file_pkg;

    localparam int ROB_IDX_LN = 4;
    localparam int REG_NUM    = 32;
    localparam int REG_IDX_W  = 5;
    localparam int WORD_W     = 32;
    localparam int NO_ROB_TAG = 0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]    word_t;

endpackage

// File: rtl/reg_rename_file_read_port.sv
// Source read port: maps (rs, its stored val/tag, commit bus) to (busy, tag, val).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the commit bus is observed only for the same-cycle bypass.
module reg_read_port
    import reg_rename_file_pkg::*;
#(
    parameter int ROB_BIT = ROB_IDX_LN
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [WORD_W-1:0]    st_val,
    input  logic [ROB_BIT-1:0]   st_tag,
    input  logic                 rob_wr_ena,
    input  logic [REG_IDX_W-1:0] rob_wr_rd,
    input  logic [WORD_W-1:0]    rob_wr_val,
    input  logic [ROB_BIT-1:0]   rob_wr_idx,
    output logic                 busy,
    output logic [ROB_BIT-1:0]   tag,
    output logic [WORD_W-1:0]    val
);

    logic rs_is_zero;
    logic bypass_hit;

    assign rs_is_zero = (rs == '0);
    // The ROB frees its entry on the commit cycle, so a matching commit must be forwarded now.
    assign bypass_hit = rob_wr_ena && (rob_wr_rd == rs) && !rs_is_zero && (st_tag == rob_wr_idx);

    // x0 reads as zero; a matching commit is forwarded; otherwise the stored state is returned.
    always_comb begin
        busy = 1'b0;
        tag  = ROB_BIT'(NO_ROB_TAG);
        val  = '0;
        if (rs_is_zero) begin
            busy = 1'b0;
        end else if (bypass_hit) begin
            val = rob_wr_val;
        end else begin
            busy = (st_tag != ROB_BIT'(NO_ROB_TAG));
            tag  = st_tag;
            val  = st_val;
        end
    end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags; the sink of the ROB commit port.
// Latency: reads are combinational (zero cycles) with commit bypass; updates land on the next clk edge.
// Backpressure: rdy=0 only blocks renames; commits and rollback are single-cycle pulses and always apply.
// Optional build: REG_RENAME_DBG_EN adds a debug register read port and a commit counter.
module reg_rename_file
    import reg_rename_file_pkg::*;
#(
    parameter int ROB_BIT = ROB_IDX_LN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rb_ena,
    input  logic                 id_rn_ena,
    input  logic [REG_IDX_W-1:0] id_rn_rd,
    input  logic [ROB_BIT-1:0]   id_rn_tag,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 id_rs1_busy,
    output logic [ROB_BIT-1:0]   id_rs1_tag,
    output logic [WORD_W-1:0]    id_rs1_val,
    output logic                 id_rs2_busy,
    output logic [ROB_BIT-1:0]   id_rs2_tag,
    output logic [WORD_W-1:0]    id_rs2_val,
`ifdef REG_RENAME_DBG_EN
    input  logic [REG_IDX_W-1:0] dbg_reg_idx,
    output logic [WORD_W-1:0]    dbg_reg_val,
    output logic [31:0]          dbg_commit_cnt,
`endif
    input  logic                 rob_wr_ena,
    input  logic [REG_IDX_W-1:0] rob_wr_rd,
    input  logic [WORD_W-1:0]    rob_wr_val,
    input  logic [ROB_BIT-1:0]   rob_wr_idx
);

    word_t              val_q [REG_NUM];
    logic [ROB_BIT-1:0] tag_q [REG_NUM];

    logic commit_wr;
    logic rename_wr;

    assign commit_wr = rob_wr_ena && (rob_wr_rd != '0);
    assign rename_wr = rdy && !rb_ena && id_rn_ena && (id_rn_rd != '0);

    // Storage update: commit first, then rollback or rename so a same-cycle rename tag wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= ROB_BIT'(NO_ROB_TAG);
            end
        end else begin
            if (commit_wr) begin
                val_q[rob_wr_rd] <= rob_wr_val;
                // A mismatched tag means a younger rename owns rd; keep it pending.
                if (tag_q[rob_wr_rd] == rob_wr_idx) begin
                    tag_q[rob_wr_rd] <= ROB_BIT'(NO_ROB_TAG);
                end
            end
            if (rb_ena) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    tag_q[i] <= ROB_BIT'(NO_ROB_TAG);
                end
            end else if (rename_wr) begin
                tag_q[id_rn_rd] <= id_rn_tag;
            end
        end
    end

    // Tag 0 means "not renamed", so decode must never allocate it.
    a_rn_tag_nonzero: assert property (@(posedge clk) disable iff (!rst)
        rename_wr |-> (id_rn_tag != ROB_BIT'(NO_ROB_TAG)));

    reg_read_port #(.ROB_BIT(ROB_BIT)) u_rs1 (
        .rs         (id_rs1),
        .st_val     (val_q[id_rs1]),
        .st_tag     (tag_q[id_rs1]),
        .rob_wr_ena (rob_wr_ena),
        .rob_wr_rd  (rob_wr_rd),
        .rob_wr_val (rob_wr_val),
        .rob_wr_idx (rob_wr_idx),
        .busy       (id_rs1_busy),
        .tag        (id_rs1_tag),
        .val        (id_rs1_val)
    );

    reg_read_port #(.ROB_BIT(ROB_BIT)) u_rs2 (
        .rs         (id_rs2),
        .st_val     (val_q[id_rs2]),
        .st_tag     (tag_q[id_rs2]),
        .rob_wr_ena (rob_wr_ena),
        .rob_wr_rd  (rob_wr_rd),
        .rob_wr_val (rob_wr_val),
        .rob_wr_idx (rob_wr_idx),
        .busy       (id_rs2_busy),
        .tag        (id_rs2_tag),
        .val        (id_rs2_val)
    );

`ifdef REG_RENAME_DBG_EN
    logic [31:0] commit_cnt_q;

    assign dbg_reg_val    = val_q[dbg_reg_idx];
    assign dbg_commit_cnt = commit_cnt_q;

    // Count every commit that actually writes a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_cnt_q <= '0;
        end else if (commit_wr) begin
            commit_cnt_q <= commit_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed table-driven bench for reg_rename_file plus a hand-written mid-operation reset sequence.
// Each row drives one cycle of inputs; reads are checked before the edge, so they reflect prior state.
// Optional debug ports are connected and checked only when REG_RENAME_DBG_EN is defined.
module tb_reg_rename_file;

    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy, rb_ena, id_rn_ena, rob_wr_ena;
    logic [4:0]    id_rn_rd, id_rs1, id_rs2, rob_wr_rd;
    logic [RB-1:0] id_rn_tag, rob_wr_idx;
    logic [31:0]   rob_wr_val;
    logic          id_rs1_busy, id_rs2_busy;
    logic [RB-1:0] id_rs1_tag, id_rs2_tag;
    logic [31:0]   id_rs1_val, id_rs2_val;
`ifdef REG_RENAME_DBG_EN
    logic [4:0]    dbg_reg_idx = 5'd5;
    logic [31:0]   dbg_reg_val;
    logic [31:0]   dbg_commit_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_rename_file #(.ROB_BIT(RB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rb_ena      (rb_ena),
        .id_rn_ena   (id_rn_ena),
        .id_rn_rd    (id_rn_rd),
        .id_rn_tag   (id_rn_tag),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_busy (id_rs1_busy),
        .id_rs1_tag  (id_rs1_tag),
        .id_rs1_val  (id_rs1_val),
        .id_rs2_busy (id_rs2_busy),
        .id_rs2_tag  (id_rs2_tag),
        .id_rs2_val  (id_rs2_val),
`ifdef REG_RENAME_DBG_EN
        .dbg_reg_idx    (dbg_reg_idx),
        .dbg_reg_val    (dbg_reg_val),
        .dbg_commit_cnt (dbg_commit_cnt),
`endif
        .rob_wr_ena  (rob_wr_ena),
        .rob_wr_rd   (rob_wr_rd),
        .rob_wr_val  (rob_wr_val),
        .rob_wr_idx  (rob_wr_idx)
    );

    typedef struct {
        logic          rdy, rb, rn_ena;
        logic [4:0]    rn_rd;
        logic [RB-1:0] rn_tag;
        logic          wr_ena;
        logic [4:0]    wr_rd;
        logic [31:0]   wr_val;
        logic [RB-1:0] wr_idx;
        logic [4:0]    rs1, rs2;
        logic          e1b;
        logic [RB-1:0] e1t;
        logic [31:0]   e1v;
        logic          e2b;
        logic [RB-1:0] e2t;
        logic [31:0]   e2v;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic rb, input logic rne, input logic [4:0] rnd,
                       input logic [RB-1:0] rnt, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wv, input logic [RB-1:0] wi,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic b1, input logic [RB-1:0] t1, input logic [31:0] v1,
                       input logic b2, input logic [RB-1:0] t2, input logic [31:0] v2);
        vec_t v;
        v.rdy = r; v.rb = rb; v.rn_ena = rne; v.rn_rd = rnd; v.rn_tag = rnt;
        v.wr_ena = we; v.wr_rd = wrd; v.wr_val = wv; v.wr_idx = wi;
        v.rs1 = s1; v.rs2 = s2;
        v.e1b = b1; v.e1t = t1; v.e1v = v1; v.e2b = b2; v.e2t = t2; v.e2v = v2;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ports(input string nm, input logic b1, input logic [RB-1:0] t1,
                             input logic [31:0] v1, input logic b2, input logic [RB-1:0] t2,
                             input logic [31:0] v2);
        chk({nm, " rs1_busy"}, 32'(id_rs1_busy), 32'(b1));
        chk({nm, " rs1_tag"},  32'(id_rs1_tag),  32'(t1));
        chk({nm, " rs1_val"},  id_rs1_val,       v1);
        chk({nm, " rs2_busy"}, 32'(id_rs2_busy), 32'(b2));
        chk({nm, " rs2_tag"},  32'(id_rs2_tag),  32'(t2));
        chk({nm, " rs2_val"},  id_rs2_val,       v2);
    endtask

    task automatic idle();
        rdy = 1'b1; rb_ena = 1'b0; id_rn_ena = 1'b0; id_rn_rd = '0; id_rn_tag = '0;
        rob_wr_ena = 1'b0; rob_wr_rd = '0; rob_wr_val = '0; rob_wr_idx = '0;
    endtask

    initial begin
        idle();
        id_rs1 = 5'd1; id_rs2 = 5'd31;

        //   rdy rb rn  rd  tag we  wrd val           idx  rs1 rs2  b1 t1 v1             b2 t2 v2
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  1, 31,  0, 0, 32'h0,        0, 0, 32'h0);      // 0 reset state
        add(1, 0, 1,  5, 3, 0,  0, 32'h0,         0,  5,  0,  0, 0, 32'h0,        0, 0, 32'h0);      // 1 rename x5; reads see old tag
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  5,  0,  1, 3, 32'h0,        0, 0, 32'h0);      // 2 x5 pending
        add(1, 0, 0,  0, 0, 1,  5, 32'hDEAD,      3,  5,  5,  0, 0, 32'hDEAD,     0, 0, 32'hDEAD);   // 3 commit bypass
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  5,  5,  0, 0, 32'hDEAD,     0, 0, 32'hDEAD);   // 4 tag cleared
        add(1, 0, 1,  7, 2, 0,  0, 32'h0,         0,  7,  0,  0, 0, 32'h0,        0, 0, 32'h0);      // 5 rename x7 tag2
        add(1, 0, 1,  7, 4, 0,  0, 32'h0,         0,  7,  0,  1, 2, 32'h0,        0, 0, 32'h0);      // 6 rename x7 tag4
        add(1, 0, 0,  0, 0, 1,  7, 32'h11,        2,  7,  5,  1, 4, 32'h0,        0, 0, 32'hDEAD);   // 7 stale commit, no bypass
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  7,  0,  1, 4, 32'h11,       0, 0, 32'h0);      // 8 value written, tag4 kept
        add(1, 0, 1,  9, 6, 1,  9, 32'h22,        5,  9,  7,  0, 0, 32'h0,        1, 4, 32'h11);     // 9 commit+rename x9
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  9,  0,  1, 6, 32'h22,       0, 0, 32'h0);      // 10 new tag wins
        add(1, 0, 1,  0, 1, 1,  0, 32'hFF,        1,  0,  0,  0, 0, 32'h0,        0, 0, 32'h0);      // 11 x0 rename/commit
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  0,  0,  0, 0, 32'h0,        0, 0, 32'h0);      // 12 x0 still zero
        add(1, 0, 1,  1, 1, 0,  0, 32'h0,         0,  1,  0,  0, 0, 32'h0,        0, 0, 32'h0);      // 13 rename x1 tag1
        add(1, 0, 1,  2, 2, 0,  0, 32'h0,         0,  1,  0,  1, 1, 32'h0,        0, 0, 32'h0);      // 14 rename x2 tag2
        add(1, 0, 1,  3, 7, 0,  0, 32'h0,         0,  2,  0,  1, 2, 32'h0,        0, 0, 32'h0);      // 15 rename x3 tag7
        add(1, 1, 1,  4, 8, 1,  1, 32'h1004,      1,  1,  3,  0, 0, 32'h1004,     1, 7, 32'h0);      // 16 rollback+commit+rename
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  1,  2,  0, 0, 32'h1004,     0, 0, 32'h0);      // 17 tags cleared
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  3,  4,  0, 0, 32'h0,        0, 0, 32'h0);      // 18 rename dropped
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  9,  7,  0, 0, 32'h22,       0, 0, 32'h11);     // 19 rollback cleared x9/x7
        add(0, 0, 1,  4, 2, 1,  6, 32'h33,        5,  4,  6,  0, 0, 32'h0,        0, 0, 32'h0);      // 20 rdy=0
        add(1, 0, 0,  0, 0, 0,  0, 32'h0,         0,  4,  6,  0, 0, 32'h0,        0, 0, 32'h33);     // 21 x4 not renamed, x6 written

        // Checks during reset, then release away from the clock edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_ports("in_reset", 0, 0, 32'h0, 0, 0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            rdy = vq[i].rdy; rb_ena = vq[i].rb; id_rn_ena = vq[i].rn_ena;
            id_rn_rd = vq[i].rn_rd; id_rn_tag = vq[i].rn_tag;
            rob_wr_ena = vq[i].wr_ena; rob_wr_rd = vq[i].wr_rd;
            rob_wr_val = vq[i].wr_val; rob_wr_idx = vq[i].wr_idx;
            id_rs1 = vq[i].rs1; id_rs2 = vq[i].rs2;
            @(negedge clk);
            chk_ports($sformatf("vec%0d", i), vq[i].e1b, vq[i].e1t, vq[i].e1v,
                      vq[i].e2b, vq[i].e2t, vq[i].e2v);
            @(posedge clk);
            #1;
        end
        idle();

`ifdef REG_RENAME_DBG_EN
        #1;
        chk("dbg_reg_val", dbg_reg_val, 32'hDEAD);
        chk("dbg_commit_cnt", dbg_commit_cnt, 32'd5);
`endif

        // Mid-operation reset: build pending state, then drop rst between edges.
        id_rn_ena = 1'b1; id_rn_rd = 5'd10; id_rn_tag = 4'd5;
        rob_wr_ena = 1'b1; rob_wr_rd = 5'd11; rob_wr_val = 32'h55; rob_wr_idx = 4'd9;
        @(posedge clk);
        #1;
        idle();
        id_rs1 = 5'd10; id_rs2 = 5'd11;
        @(negedge clk);
        chk_ports("pre_rst", 1, 4'd5, 32'h0, 0, 0, 32'h55);
        #2;
        rst = 1'b0;
        #1;
        chk_ports("mid_rst", 0, 0, 32'h0, 0, 0, 32'h0);
        id_rs1 = 5'd5; id_rs2 = 5'd1;
        #1;
        chk_ports("mid_rst_old", 0, 0, 32'h0, 0, 0, 32'h0);
`ifdef REG_RENAME_DBG_EN
        chk("dbg_cnt_rst", dbg_commit_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
